// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder
// Purpose  : Byte-serial memory bus responder serving RAM and an I/O window
//            (tx FIFO, rx byte, cycle counter, program-stop flag).
// Revision : 1.0
// ============================================================================
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_din,
  input  logic        mem_wr,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);

  localparam int c_ptr_w = $clog2(TX_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(TX_DEPTH);
  localparam logic [c_cnt_w-1:0] c_near_full = c_cnt_w'(TX_DEPTH - 1);

  // Address decode
  logic                  w_io_sel;
  logic                  w_win_sel;
  logic [2:0]            w_io_reg;
  logic                  w_acc_rd;
  logic                  w_acc_wr;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic                  w_unused;

  assign w_io_sel   = (mem_a[17:16] == 2'b11);
  assign w_win_sel  = w_io_sel && (mem_a[15:3] == 13'd0);
  assign w_io_reg   = mem_a[2:0];
  assign w_acc_rd   = rdy && !mem_wr;
  assign w_acc_wr   = rdy && mem_wr;
  assign w_ram_addr = mem_a[ADDR_WIDTH-1:0];
  assign w_unused   = ^mem_a[31:18];

  // Registered state
  logic [7:0]         r_dout;
  logic [31:0]        r_counter;
  logic [23:0]        r_snap;
  logic               r_prog_stop;
  logic               r_tx_overflow;
  logic               r_buf_full;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_nxt;

  logic [7:0] r_ram  [2**ADDR_WIDTH];
  logic [7:0] r_fifo [TX_DEPTH];

  // RAM array
  always_ff @(posedge clk) begin
    if (w_acc_wr && !w_io_sel) begin
      r_ram[w_ram_addr] <= mem_din;
    end
  end

  // Read data mux
  logic [7:0] w_rd_data;

  always_comb begin
    w_rd_data = 8'h00;
    if (!w_io_sel) begin
      w_rd_data = r_ram[w_ram_addr];
    end else if (w_win_sel) begin
      case (w_io_reg)
        3'd0:    w_rd_data = rx_valid ? rx_data : 8'h00;
        3'd4:    w_rd_data = r_counter[7:0];
        3'd5:    w_rd_data = r_snap[7:0];
        3'd6:    w_rd_data = r_snap[15:8];
        3'd7:    w_rd_data = r_snap[23:16];
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  logic w_rx_rd;
  logic w_cnt_rd;
  logic w_stop_wr;

  assign w_rx_rd   = w_acc_rd && w_win_sel && (w_io_reg == 3'd0);
  assign w_cnt_rd  = w_acc_rd && w_win_sel && (w_io_reg == 3'd4);
  assign w_stop_wr = w_acc_wr && w_win_sel && (w_io_reg == 3'd4);
  assign rx_ready  = w_rx_rd && rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout      <= 8'h00;
      r_counter   <= 32'd0;
      r_snap      <= 24'd0;
      r_prog_stop <= 1'b0;
    end else begin
      if (rdy) begin
        r_counter <= r_counter + 32'd1;
      end
      if (w_acc_rd) begin
        r_dout <= w_rd_data;
      end
      if (w_cnt_rd) begin
        r_snap <= r_counter[31:8];
      end
      if (w_stop_wr) begin
        r_prog_stop <= 1'b1;
      end
    end
  end

  // tx FIFO: a full FIFO still accepts a push when a pop frees a slot the same cycle
  logic w_tx_wr;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  assign w_tx_wr = w_acc_wr && w_win_sel && (w_io_reg == 3'd0) &&
                   (mem_din != 8'h00) && !r_prog_stop;
  assign w_pop   = (r_count != '0) && tx_ready;
  assign w_full  = (r_count == c_depth);
  assign w_push  = w_tx_wr && (!w_full || w_pop);
  assign w_drop  = w_tx_wr && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_w'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= mem_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_buf_full    <= 1'b0;
      r_tx_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count    <= w_count_nxt;
      r_buf_full <= (w_count_nxt >= c_near_full);
      if (w_drop) begin
        r_tx_overflow <= 1'b1;
      end
    end
  end

  assign tx_valid       = (r_count != '0);
  assign tx_data        = tx_valid ? r_fifo[r_rd_ptr] : 8'h00;
  assign mem_dout       = r_dout;
  assign io_buffer_full = r_buf_full;
  assign prog_stop      = r_prog_stop;
  assign tx_overflow    = r_tx_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_responder
// Purpose  : Self-checking bench for mem_io_responder (RAM, I/O window, tx FIFO).
// Revision : 1.0
// ============================================================================
module tb_mem_io_responder;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_stop;
  logic        tx_overflow;

  mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .mem_a          (mem_a),
    .mem_din        (mem_din),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .prog_stop      (prog_stop),
    .tx_overflow    (tx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec;
  int         n_bad;
  int         rdy_cycles;
  logic [7:0] last_exp;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  e;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One bus cycle; expected mem_dout is queued at drive time and compared after the edge
  task automatic bus(input bit r, input logic [31:0] a, input bit w,
                     input logic [7:0] d, input logic [7:0] e, input bit erx);
    logic [7:0] got;
    @(negedge clk);
    rdy = r; mem_a = a; mem_wr = w; mem_din = d;
    if (r && !w) exp_q.push_back(e);
    else         exp_q.push_back(last_exp);
    #1 check("rx_ready", rx_ready, erx);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("mem_dout", mem_dout, got);
    last_exp = got;
    if (r) rdy_cycles++;
  endtask

  task automatic tx_wr(input logic [7:0] d, input bit acc);
    if (acc) tx_q.push_back(d);
    bus(1'b1, 32'h0003_0000, 1'b1, d, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rdy = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rdy = 1'b0; mem_wr = 1'b0; mem_a = '0; mem_din = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_cycles = 0; last_exp = 8'h00;
    exp_q.delete(); tx_q.delete();
  endtask

  // tx scoreboard: sampled just before the edge where the pop takes effect
  always @(negedge clk) begin
    logic [7:0] want;
    #4;
    if (rst_n && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL tx_extra: got %0h expected none", tx_data);
      end else begin
        want = tx_q.pop_front();
        check("tx_data", tx_data, want);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; rdy = 1'b0; mem_a = '0; mem_din = '0; mem_wr = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;

    tbl[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
    tbl[1]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    tbl[2]  = '{1'b0, 32'h0002_0010, 8'h00, 8'hA5};
    tbl[3]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 8'h00};
    tbl[4]  = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h3C};
    tbl[5]  = '{1'b1, 32'hFFFE_0010, 8'h5A, 8'h00};
    tbl[6]  = '{1'b0, 32'h0000_0010, 8'h00, 8'h5A};
    tbl[7]  = '{1'b1, 32'h0003_0001, 8'hEE, 8'h00};
    tbl[8]  = '{1'b0, 32'h0003_0001, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h3C};
    tbl[10] = '{1'b0, 32'h0003_0008, 8'h00, 8'h00};
    tbl[11] = '{1'b0, 32'h0003_0000, 8'h00, 8'h00};

    do_reset();
    check("rst_mem_dout", mem_dout, 8'h00);
    check("rst_buf_full", io_buffer_full, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_prog_stop", prog_stop, 1'b0);
    check("rst_tx_overflow", tx_overflow, 1'b0);

    for (int i = 0; i < 12; i++) begin
      bus(1'b1, tbl[i].a, tbl[i].wr, tbl[i].d, tbl[i].e, 1'b0);
    end

    // rx byte input
    rx_valid = 1'b1; rx_data = 8'h33;
    bus(1'b1, 32'h0003_0000, 1'b0, 8'h00, 8'h33, 1'b1);
    bus(1'b1, 32'h0003_0001, 1'b0, 8'h00, 8'h00, 1'b0);
    bus(1'b1, 32'h0000_0010, 1'b0, 8'h00, 8'h5A, 1'b0);
    rx_valid = 1'b0;
    bus(1'b1, 32'h0003_0000, 1'b0, 8'h00, 8'h00, 1'b0);

    // tx basic: 'H','i',0x00
    tx_ready = 1'b0;
    tx_wr(8'h48, 1'b1);
    check("tx_valid_first", tx_valid, 1'b1);
    check("tx_head", tx_data, 8'h48);
    tx_wr(8'h69, 1'b1);
    tx_wr(8'h00, 1'b0);
    check("buf_full_2", io_buffer_full, 1'b0);
    tx_ready = 1'b1;
    idle(3);
    tx_ready = 1'b0;
    check("tx_drained", tx_valid, 1'b0);
    check("tx_q_basic", tx_q.size(), 0);

    // tx fill to capacity, overflow, and push-with-pop at full
    for (int i = 1; i <= 16; i++) begin
      tx_wr(8'(i), 1'b1);
      if (i == 14) check("buf_full_14", io_buffer_full, 1'b0);
      if (i == 15) check("buf_full_15", io_buffer_full, 1'b1);
      if (i == 16) check("ovf_16", tx_overflow, 1'b0);
    end
    tx_wr(8'h77, 1'b0);
    check("ovf_17", tx_overflow, 1'b1);
    tx_ready = 1'b1;
    tx_wr(8'h88, 1'b1);
    tx_ready = 1'b0;
    check("buf_full_pushpop", io_buffer_full, 1'b1);
    tx_ready = 1'b1;
    idle(20);
    tx_ready = 1'b0;
    check("tx_drained_full", tx_valid, 1'b0);
    check("tx_q_full", tx_q.size(), 0);
    check("ovf_sticky", tx_overflow, 1'b1);

    // program stop
    bus(1'b1, 32'h0003_0004, 1'b1, 8'h01, 8'h00, 1'b0);
    check("prog_stop", prog_stop, 1'b1);
    tx_wr(8'h41, 1'b0);
    check("stop_blocks_tx", tx_valid, 1'b0);
    bus(1'b1, 32'h0000_0040, 1'b1, 8'h77, 8'h00, 1'b0);
    bus(1'b1, 32'h0000_0040, 1'b0, 8'h00, 8'h77, 1'b0);

    // cycle counter and snapshot
    do_reset();
    check("rst2_prog_stop", prog_stop, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      bus(1'b1, 32'h0000_0100, 1'b1, 8'h00, 8'h00, 1'b0);
    end
    bus(1'b1, 32'h0003_0004, 1'b0, 8'h00, 8'hE8, 1'b0);
    bus(1'b1, 32'h0003_0005, 1'b0, 8'h00, 8'h03, 1'b0);
    bus(1'b1, 32'h0003_0006, 1'b0, 8'h00, 8'h00, 1'b0);
    bus(1'b1, 32'h0003_0007, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 19; i++) begin
      bus(1'b1, 32'h0000_0100, 1'b1, 8'h00, 8'h00, 1'b0);
    end
    check("cycles_1023", rdy_cycles, 1023);
    bus(1'b1, 32'h0003_0004, 1'b0, 8'h00, 8'hFF, 1'b0);
    bus(1'b1, 32'h0003_0006, 1'b0, 8'h00, 8'h00, 1'b0);
    bus(1'b1, 32'h0003_0005, 1'b0, 8'h00, 8'h03, 1'b0);
    rx_valid = 1'b1; rx_data = 8'h99;
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 32'h0003_0000, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    rx_valid = 1'b0;
    bus(1'b1, 32'h0003_0004, 1'b0, 8'h00, 8'h02, 1'b0);
    bus(1'b1, 32'h0003_0005, 1'b0, 8'h00, 8'h04, 1'b0);

    // reset in the middle of a tx drain
    tx_ready = 1'b0;
    tx_wr(8'h11, 1'b1);
    tx_wr(8'h22, 1'b1);
    tx_wr(8'h33, 1'b1);
    tx_wr(8'h44, 1'b1);
    bus(1'b1, 32'h0000_0010, 1'b0, 8'h00, 8'h5A, 1'b0);
    tx_ready = 1'b1;
    idle(1);
    check("mid_tx_valid", tx_valid, 1'b1);
    check("mid_tx_head", tx_data, 8'h22);
    #1 rst_n = 1'b0;
    #1;
    tx_q.delete();
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_tx_data", tx_data, 8'h00);
    check("arst_mem_dout", mem_dout, 8'h00);
    check("arst_buf_full", io_buffer_full, 1'b0);
    check("arst_rx_ready", rx_ready, 1'b0);
    check("arst_prog_stop", prog_stop, 1'b0);
    check("arst_tx_overflow", tx_overflow, 1'b0);
    tx_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdy_cycles = 0; last_exp = 8'h00; exp_q.delete();
    idle(2);
    check("post_rst_tx_valid", tx_valid, 1'b0);
    check("tx_q_end", tx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
